// File: rtl/ccip_port_mux.sv
// ---------------------------------------------------------------------------
// ccip_port_mux
//
// N-to-1 CCI-P request multiplexer / response demultiplexer. Several AFU
// engines share one MPF-facing CCI-P port through this block.
//
//  * c0 (read) and c1 (write) requests are arbitrated by two independent
//    round-robin arbiters. The winning header is registered with the port ID
//    written into mdata[15:16-PID_W]. Engines must keep their own tags in
//    mdata[15-PID_W:0].
//  * Read and write responses are steered back to the originating port using
//    the same mdata bits. Those bits are cleared in the returned header.
//  * Each port has an in-flight read counter. A port is not granted reads
//    while its counter is at MAX_OUTSTANDING.
//  * err_bad_rsp is sticky until reset. It is set by a response carrying an
//    ID >= NUM_PORTS, which is dropped. It is also set by a read response to
//    a port with no reads in flight; that response is still delivered.
//
// Handshake: a request on port i transfers in a cycle where port_*_valid[i]
// and port_*_ready[i] are both high. The ready vector is combinational from
// the current valids, the almost-full inputs and the counters. It is one-hot
// or all zero. A transfer in cycle N appears on afu_tx_* in cycle N+1 for one
// cycle. The spl_rx_* responses are strobe-only: there is no ready, and they
// appear on port_rx_* one cycle later.
//
// Ports
//   clk, spl_reset_n            clock, asynchronous active-low reset
//   port_rd_valid/ready/hdr     per-port c0 read request
//   port_wr_valid/ready/hdr     per-port c1 write request
//   port_wr_data                per-port write data (512b)
//   port_rx_rd_valid            one-hot read response strobe
//   port_rx_wr_valid            one-hot write response strobe
//   port_rx_rd_hdr              shared read response header
//   port_rx_data                shared read response data
//   port_rx_wr_hdr              shared write response header
//   port_rd_outstanding         per-port in-flight read count
//   spl_tx_rd/wr_almostfull     CCI-P back-pressure
//   afu_tx_rd_*, afu_tx_wr_*    merged requests towards MPF
//   afu_tx_data                 merged write data towards MPF
//   spl_rx_rd_*, spl_rx_wr_*    responses from MPF
//   err_bad_rsp                 sticky bad-response flag
//   port_stats                  per-port read-grant counters
//
// Optional feature: define CCIP_PORT_MUX_STATS_EN to build the 32-bit
// per-port read-grant counters. Without it, port_stats is tied to zero.
//
// Header widths default to the CCI-P t_ccip_c{0,1}_{Req,Rsp}MemHdr sizes. In
// all four formats mdata occupies bits [15:0].
// ---------------------------------------------------------------------------
module ccip_port_mux #(
    parameter int  NUM_PORTS       = 4,
    parameter int  MAX_OUTSTANDING = 64,
    parameter int  C0_REQ_W        = 74,
    parameter int  C1_REQ_W        = 80,
    parameter int  C0_RSP_W        = 28,
    parameter int  C1_RSP_W        = 28,
    localparam int PID_W           = $clog2(NUM_PORTS),
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                                clk,
    input  logic                                spl_reset_n,
    input  logic [NUM_PORTS-1:0]                port_rd_valid,
    output logic [NUM_PORTS-1:0]                port_rd_ready,
    input  logic [NUM_PORTS-1:0][C0_REQ_W-1:0]  port_rd_hdr,
    input  logic [NUM_PORTS-1:0]                port_wr_valid,
    output logic [NUM_PORTS-1:0]                port_wr_ready,
    input  logic [NUM_PORTS-1:0][C1_REQ_W-1:0]  port_wr_hdr,
    input  logic [NUM_PORTS-1:0][511:0]         port_wr_data,
    output logic [NUM_PORTS-1:0]                port_rx_rd_valid,
    output logic [NUM_PORTS-1:0]                port_rx_wr_valid,
    output logic [C0_RSP_W-1:0]                 port_rx_rd_hdr,
    output logic [511:0]                        port_rx_data,
    output logic [C1_RSP_W-1:0]                 port_rx_wr_hdr,
    output logic [NUM_PORTS-1:0][CNT_W-1:0]     port_rd_outstanding,
    input  logic                                spl_tx_rd_almostfull,
    input  logic                                spl_tx_wr_almostfull,
    output logic                                afu_tx_rd_valid,
    output logic [C0_REQ_W-1:0]                 afu_tx_rd_hdr,
    output logic                                afu_tx_wr_valid,
    output logic [C1_REQ_W-1:0]                 afu_tx_wr_hdr,
    output logic [511:0]                        afu_tx_data,
    input  logic                                spl_rx_rd_valid,
    input  logic [C0_RSP_W-1:0]                 spl_rx_rd_hdr,
    input  logic [511:0]                        spl_rx_data,
    input  logic                                spl_rx_wr_valid,
    input  logic [C1_RSP_W-1:0]                 spl_rx_wr_hdr,
    output logic                                err_bad_rsp,
    output logic [NUM_PORTS-1:0][31:0]          port_stats
);

    // Lowest mdata bit that carries the port ID.
    localparam int PID_LO = 16 - PID_W;

    typedef logic [PID_W-1:0] pid_t;
    typedef logic [CNT_W-1:0] cnt_t;

    // Returns {found, index} of the first set bit in elig at or after ptr,
    // wrapping modulo NUM_PORTS.
    function automatic logic [PID_W:0] rr_pick(input logic [NUM_PORTS-1:0] elig,
                                               input pid_t ptr);
        logic found;
        pid_t idx;
        int   s;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            s = int'(ptr) + k;
            if (s >= NUM_PORTS) s = s - NUM_PORTS;
            if (!found && elig[pid_t'(s)]) begin
                found = 1'b1;
                idx   = pid_t'(s);
            end
        end
        return {found, idx};
    endfunction

    function automatic pid_t next_ptr(input pid_t g);
        return (int'(g) == NUM_PORTS - 1) ? '0 : g + pid_t'(1);
    endfunction

    // An ID field is only meaningful when it names an existing port. This
    // matters when NUM_PORTS is not a power of two.
    function automatic logic pid_ok(input pid_t pid);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (pid == pid_t'(i)) ok = 1'b1;
        end
        return ok;
    endfunction

    // ---------------------------------------------------------------- state
    // run_q holds off all grants for the first cycle after reset, so the
    // readies stay low even if engines come out of reset already requesting.
    logic                            run_q;
    pid_t                            rd_ptr_q, rd_ptr_d;
    pid_t                            wr_ptr_q, wr_ptr_d;
    logic [NUM_PORTS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic                            err_q, err_d;
    logic                            tx_rd_valid_q, tx_wr_valid_q;
    logic [C0_REQ_W-1:0]             tx_rd_hdr_q;
    logic [C1_REQ_W-1:0]             tx_wr_hdr_q;
    logic [511:0]                    tx_data_q;
    logic [NUM_PORTS-1:0]            rx_rd_valid_q, rx_wr_valid_q;
    logic [C0_RSP_W-1:0]             rx_rd_hdr_q;
    logic [C1_RSP_W-1:0]             rx_wr_hdr_q;
    logic [511:0]                    rx_data_q;

    // ----------------------------------------------------------- arbitration
    logic [NUM_PORTS-1:0] rd_elig, wr_elig;
    logic                 rd_any, wr_any;
    pid_t                 rd_idx, wr_idx;
    logic [C0_REQ_W-1:0]  rd_hdr_stamped;
    logic [C1_REQ_W-1:0]  wr_hdr_stamped;

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            rd_elig[i] = run_q && port_rd_valid[i] && !spl_tx_rd_almostfull &&
                         (cnt_q[i] < cnt_t'(MAX_OUTSTANDING));
            wr_elig[i] = run_q && port_wr_valid[i] && !spl_tx_wr_almostfull;
        end
    end

    always_comb begin
        {rd_any, rd_idx} = rr_pick(rd_elig, rd_ptr_q);
        {wr_any, wr_idx} = rr_pick(wr_elig, wr_ptr_q);

        port_rd_ready = '0;
        port_wr_ready = '0;
        if (rd_any) port_rd_ready[rd_idx] = 1'b1;
        if (wr_any) port_wr_ready[wr_idx] = 1'b1;

        rd_ptr_d = rd_any ? next_ptr(rd_idx) : rd_ptr_q;
        wr_ptr_d = wr_any ? next_ptr(wr_idx) : wr_ptr_q;

        rd_hdr_stamped                = port_rd_hdr[rd_idx];
        rd_hdr_stamped[15:PID_LO]     = rd_idx;
        wr_hdr_stamped                = port_wr_hdr[wr_idx];
        wr_hdr_stamped[15:PID_LO]     = wr_idx;
    end

    // ------------------------------------------------------ response decode
    pid_t                 rx_rd_pid, rx_wr_pid;
    logic                 rx_rd_ok, rx_wr_ok;
    logic                 rx_rd_bad, rx_wr_bad;
    logic [NUM_PORTS-1:0] rx_rd_hit, rx_wr_hit;
    logic [C0_RSP_W-1:0]  rx_rd_hdr_clr;
    logic [C1_RSP_W-1:0]  rx_wr_hdr_clr;

    always_comb begin
        rx_rd_pid = spl_rx_rd_hdr[15:PID_LO];
        rx_wr_pid = spl_rx_wr_hdr[15:PID_LO];
        rx_rd_ok  = spl_rx_rd_valid &&  pid_ok(rx_rd_pid);
        rx_rd_bad = spl_rx_rd_valid && !pid_ok(rx_rd_pid);
        rx_wr_ok  = spl_rx_wr_valid &&  pid_ok(rx_wr_pid);
        rx_wr_bad = spl_rx_wr_valid && !pid_ok(rx_wr_pid);

        rx_rd_hit = '0;
        rx_wr_hit = '0;
        if (rx_rd_ok) rx_rd_hit[rx_rd_pid] = 1'b1;
        if (rx_wr_ok) rx_wr_hit[rx_wr_pid] = 1'b1;

        rx_rd_hdr_clr            = spl_rx_rd_hdr;
        rx_rd_hdr_clr[15:PID_LO] = '0;
        rx_wr_hdr_clr            = spl_rx_wr_hdr;
        rx_wr_hdr_clr[15:PID_LO] = '0;
    end

    // -------------------------------------------------- outstanding counters
    // A response to a port with a zero count is flagged and not decremented.
    // A grant and a decrement in the same cycle cancel out.
    logic zero_rsp;

    always_comb begin
        cnt_d    = cnt_q;
        zero_rsp = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (rx_rd_hit[i] && cnt_q[i] == '0) zero_rsp = 1'b1;
            if (port_rd_ready[i] && !(rx_rd_hit[i] && cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] + cnt_t'(1);
            end else if (!port_rd_ready[i] && rx_rd_hit[i] && cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - cnt_t'(1);
            end
        end
        err_d = err_q | rx_rd_bad | rx_wr_bad | zero_rsp;
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk or negedge spl_reset_n) begin
        if (!spl_reset_n) begin
            run_q         <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            tx_rd_valid_q <= 1'b0;
            tx_wr_valid_q <= 1'b0;
            tx_rd_hdr_q   <= '0;
            tx_wr_hdr_q   <= '0;
            tx_data_q     <= '0;
            rx_rd_valid_q <= '0;
            rx_wr_valid_q <= '0;
            rx_rd_hdr_q   <= '0;
            rx_wr_hdr_q   <= '0;
            rx_data_q     <= '0;
        end else begin
            run_q         <= 1'b1;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            tx_rd_valid_q <= rd_any;
            tx_wr_valid_q <= wr_any;
            if (rd_any) tx_rd_hdr_q <= rd_hdr_stamped;
            if (wr_any) begin
                tx_wr_hdr_q <= wr_hdr_stamped;
                tx_data_q   <= port_wr_data[wr_idx];
            end
            rx_rd_valid_q <= rx_rd_hit;
            rx_wr_valid_q <= rx_wr_hit;
            if (rx_rd_ok) begin
                rx_rd_hdr_q <= rx_rd_hdr_clr;
                rx_data_q   <= spl_rx_data;
            end
            if (rx_wr_ok) rx_wr_hdr_q <= rx_wr_hdr_clr;
        end
    end

    // ---------------------------------------------------------- statistics
`ifdef CCIP_PORT_MUX_STATS_EN
    logic [NUM_PORTS-1:0][31:0] stats_q;

    always_ff @(posedge clk or negedge spl_reset_n) begin
        if (!spl_reset_n) begin
            stats_q <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (port_rd_ready[i]) stats_q[i] <= stats_q[i] + 32'd1;
            end
        end
    end

    assign port_stats = stats_q;
`else
    assign port_stats = '0;
`endif

    // -------------------------------------------------------------- outputs
    assign port_rd_outstanding = cnt_q;
    assign err_bad_rsp         = err_q;
    assign afu_tx_rd_valid     = tx_rd_valid_q;
    assign afu_tx_rd_hdr       = tx_rd_hdr_q;
    assign afu_tx_wr_valid     = tx_wr_valid_q;
    assign afu_tx_wr_hdr       = tx_wr_hdr_q;
    assign afu_tx_data         = tx_data_q;
    assign port_rx_rd_valid    = rx_rd_valid_q;
    assign port_rx_wr_valid    = rx_wr_valid_q;
    assign port_rx_rd_hdr      = rx_rd_hdr_q;
    assign port_rx_wr_hdr      = rx_wr_hdr_q;
    assign port_rx_data        = rx_data_q;

endmodule

// File: tb/tb_ccip_port_mux.sv
// ---------------------------------------------------------------------------
// Bench for ccip_port_mux.
//
// Instance dut:   4 ports, 64 outstanding reads. It runs directed
//                 round-robin, almost-full, same-cycle and stats scenarios,
//                 then randomized traffic. A reference model tracks the
//                 expected results.
// Instance dut_b: 3 ports, 2 outstanding reads. It covers the outstanding
//                 cap, response routing, the out-of-range ID and error-flag
//                 clearing by reset.
// ---------------------------------------------------------------------------
module tb_ccip_port_mux;
    localparam int N    = 4;
    localparam int MAXO = 64;
    localparam int CW   = 7;
    localparam int NB   = 3;
    localparam int CWB  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ------------------------------------------------------------ instance A
    logic                   rst_n;
    logic [N-1:0]           rd_valid, wr_valid;
    logic [N-1:0][73:0]     rd_hdr;
    logic [N-1:0][79:0]     wr_hdr;
    logic [N-1:0][511:0]    wr_data;
    logic                   rd_af, wr_af;
    logic                   rx_rd_v, rx_wr_v;
    logic [27:0]            rx_rd_hdr, rx_wr_hdr;
    logic [511:0]           rx_rd_data;
    logic [N-1:0]           port_rd_ready, port_wr_ready;
    logic [N-1:0]           port_rx_rd_valid, port_rx_wr_valid;
    logic [27:0]            port_rx_rd_hdr, port_rx_wr_hdr;
    logic [511:0]           port_rx_data;
    logic [N-1:0][CW-1:0]   port_rd_outstanding;
    logic                   afu_tx_rd_valid, afu_tx_wr_valid;
    logic [73:0]            afu_tx_rd_hdr;
    logic [79:0]            afu_tx_wr_hdr;
    logic [511:0]           afu_tx_data;
    logic                   err_bad_rsp;
    logic [N-1:0][31:0]     port_stats;

    ccip_port_mux #(.NUM_PORTS(N), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .spl_reset_n(rst_n),
        .port_rd_valid(rd_valid), .port_rd_ready(port_rd_ready), .port_rd_hdr(rd_hdr),
        .port_wr_valid(wr_valid), .port_wr_ready(port_wr_ready), .port_wr_hdr(wr_hdr),
        .port_wr_data(wr_data),
        .port_rx_rd_valid(port_rx_rd_valid), .port_rx_wr_valid(port_rx_wr_valid),
        .port_rx_rd_hdr(port_rx_rd_hdr), .port_rx_data(port_rx_data),
        .port_rx_wr_hdr(port_rx_wr_hdr), .port_rd_outstanding(port_rd_outstanding),
        .spl_tx_rd_almostfull(rd_af), .spl_tx_wr_almostfull(wr_af),
        .afu_tx_rd_valid(afu_tx_rd_valid), .afu_tx_rd_hdr(afu_tx_rd_hdr),
        .afu_tx_wr_valid(afu_tx_wr_valid), .afu_tx_wr_hdr(afu_tx_wr_hdr),
        .afu_tx_data(afu_tx_data),
        .spl_rx_rd_valid(rx_rd_v), .spl_rx_rd_hdr(rx_rd_hdr), .spl_rx_data(rx_rd_data),
        .spl_rx_wr_valid(rx_wr_v), .spl_rx_wr_hdr(rx_wr_hdr),
        .err_bad_rsp(err_bad_rsp), .port_stats(port_stats)
    );

    // ------------------------------------------------------------ instance B
    logic                   b_rst_n;
    logic [NB-1:0]          b_rd_valid, b_wr_valid;
    logic [NB-1:0][73:0]    b_rd_hdr;
    logic [NB-1:0][79:0]    b_wr_hdr;
    logic [NB-1:0][511:0]   b_wr_data;
    logic                   b_rx_rd_v, b_rx_wr_v;
    logic [27:0]            b_rx_rd_hdr, b_rx_wr_hdr;
    logic [511:0]           b_rx_rd_data;
    logic [NB-1:0]          b_rd_ready, b_wr_ready, b_prx_rd_v, b_prx_wr_v;
    logic [27:0]            b_prx_rd_hdr, b_prx_wr_hdr;
    logic [511:0]           b_prx_data, b_tx_data;
    logic [NB-1:0][CWB-1:0] b_cnt;
    logic                   b_tx_rd_v, b_tx_wr_v, b_err;
    logic [73:0]            b_tx_rd_hdr;
    logic [79:0]            b_tx_wr_hdr;
    logic [NB-1:0][31:0]    b_stats;

    ccip_port_mux #(.NUM_PORTS(NB), .MAX_OUTSTANDING(2)) dut_b (
        .clk(clk), .spl_reset_n(b_rst_n),
        .port_rd_valid(b_rd_valid), .port_rd_ready(b_rd_ready), .port_rd_hdr(b_rd_hdr),
        .port_wr_valid(b_wr_valid), .port_wr_ready(b_wr_ready), .port_wr_hdr(b_wr_hdr),
        .port_wr_data(b_wr_data),
        .port_rx_rd_valid(b_prx_rd_v), .port_rx_wr_valid(b_prx_wr_v),
        .port_rx_rd_hdr(b_prx_rd_hdr), .port_rx_data(b_prx_data),
        .port_rx_wr_hdr(b_prx_wr_hdr), .port_rd_outstanding(b_cnt),
        .spl_tx_rd_almostfull(1'b0), .spl_tx_wr_almostfull(1'b0),
        .afu_tx_rd_valid(b_tx_rd_v), .afu_tx_rd_hdr(b_tx_rd_hdr),
        .afu_tx_wr_valid(b_tx_wr_v), .afu_tx_wr_hdr(b_tx_wr_hdr),
        .afu_tx_data(b_tx_data),
        .spl_rx_rd_valid(b_rx_rd_v), .spl_rx_rd_hdr(b_rx_rd_hdr), .spl_rx_data(b_rx_rd_data),
        .spl_rx_wr_valid(b_rx_wr_v), .spl_rx_wr_hdr(b_rx_wr_hdr),
        .err_bad_rsp(b_err), .port_stats(b_stats)
    );

    // ------------------------------------------------------- reference model
    int           m_rptr, m_wptr;
    int           m_cnt   [N];
    int           m_stats [N];
    logic         m_err;
    logic         e_txr_v, e_txw_v;
    logic [73:0]  e_txr_hdr;
    logic [79:0]  e_txw_hdr;
    logic [511:0] e_txw_data, e_rx_data;
    logic [N-1:0] e_rxr_v, e_rxw_v;
    logic [27:0]  e_rxr_hdr, e_rxw_hdr;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [95:0] rnd96();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [27:0] rsp_hdr(input int id);
        logic [31:0] r;
        r = $urandom();
        r[15:14] = 2'(id);
        return r[27:0];
    endfunction

    task automatic model_reset();
        m_rptr = 0;
        m_wptr = 0;
        m_err  = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_cnt[i]   = 0;
            m_stats[i] = 0;
        end
    endtask

    task automatic idle();
        rd_valid   = '0;
        wr_valid   = '0;
        rd_af      = 1'b0;
        wr_af      = 1'b0;
        rx_rd_v    = 1'b0;
        rx_wr_v    = 1'b0;
        rx_rd_hdr  = '0;
        rx_wr_hdr  = '0;
        rx_rd_data = '0;
    endtask

    // Called just after a falling edge with the inputs for this cycle set.
    // Checks the combinational readies, advances the model across the next
    // rising edge, checks the registered outputs, then returns at the
    // following falling edge.
    task automatic cycle();
        int rg, wg, p, id;
        logic [N-1:0]         exp_rr, exp_wr;
        logic [N-1:0][CW-1:0] exp_cnt;
        logic [N-1:0][31:0]   exp_st;
        #1;
        rg = -1;
        wg = -1;
        for (int k = 0; k < N; k++) begin
            p = (m_rptr + k) % N;
            if (rg < 0 && rd_valid[p] && !rd_af && m_cnt[p] < MAXO) rg = p;
            p = (m_wptr + k) % N;
            if (wg < 0 && wr_valid[p] && !wr_af) wg = p;
        end
        exp_rr = (rg >= 0) ? (4'b0001 << rg) : 4'b0000;
        exp_wr = (wg >= 0) ? (4'b0001 << wg) : 4'b0000;
        chk("rd_ready", port_rd_ready, exp_rr);
        chk("wr_ready", port_wr_ready, exp_wr);

        e_txr_v = (rg >= 0);
        if (rg >= 0) begin
            e_txr_hdr        = rd_hdr[rg];
            e_txr_hdr[15:14] = 2'(rg);
            m_rptr           = (rg + 1) % N;
        end
        e_txw_v = (wg >= 0);
        if (wg >= 0) begin
            e_txw_hdr        = wr_hdr[wg];
            e_txw_hdr[15:14] = 2'(wg);
            e_txw_data       = wr_data[wg];
            m_wptr           = (wg + 1) % N;
        end
        e_rxr_v = '0;
        if (rx_rd_v) begin
            id               = int'(rx_rd_hdr[15:14]);
            e_rxr_v[id]      = 1'b1;
            e_rxr_hdr        = rx_rd_hdr;
            e_rxr_hdr[15:14] = 2'b00;
            e_rx_data        = rx_rd_data;
            if (m_cnt[id] == 0) m_err = 1'b1;
            else                m_cnt[id] = m_cnt[id] - 1;
        end
        if (rg >= 0) begin
            m_cnt[rg]   = m_cnt[rg] + 1;
            m_stats[rg] = m_stats[rg] + 1;
        end
        e_rxw_v = '0;
        if (rx_wr_v) begin
            id               = int'(rx_wr_hdr[15:14]);
            e_rxw_v[id]      = 1'b1;
            e_rxw_hdr        = rx_wr_hdr;
            e_rxw_hdr[15:14] = 2'b00;
        end

        @(posedge clk);
        #1;
        chk("tx_rd_valid", afu_tx_rd_valid, e_txr_v);
        if (e_txr_v) chk("tx_rd_hdr", afu_tx_rd_hdr, e_txr_hdr);
        chk("tx_wr_valid", afu_tx_wr_valid, e_txw_v);
        if (e_txw_v) begin
            chk("tx_wr_hdr", afu_tx_wr_hdr, e_txw_hdr);
            chk("tx_wr_data", afu_tx_data, e_txw_data);
        end
        chk("rx_rd_strobe", port_rx_rd_valid, e_rxr_v);
        if (e_rxr_v != '0) begin
            chk("rx_rd_hdr", port_rx_rd_hdr, e_rxr_hdr);
            chk("rx_rd_data", port_rx_data, e_rx_data);
        end
        chk("rx_wr_strobe", port_rx_wr_valid, e_rxw_v);
        if (e_rxw_v != '0) chk("rx_wr_hdr", port_rx_wr_hdr, e_rxw_hdr);
        for (int i = 0; i < N; i++) begin
            exp_cnt[i] = CW'(m_cnt[i]);
`ifdef CCIP_PORT_MUX_STATS_EN
            exp_st[i] = 32'(m_stats[i]);
`else
            exp_st[i] = 32'd0;
`endif
        end
        chk("rd_outstanding", port_rd_outstanding, exp_cnt);
        chk("port_stats", port_stats, exp_st);
        chk("err_bad_rsp", err_bad_rsp, m_err);
        @(negedge clk);
    endtask

    task automatic reset_a();
        idle();
        rst_n    = 1'b0;
        rd_valid = '1;
        wr_valid = '1;
        #1;
        model_reset();
        chk("rst_rd_ready", port_rd_ready, 0);
        chk("rst_wr_ready", port_wr_ready, 0);
        chk("rst_tx_valids", {afu_tx_rd_valid, afu_tx_wr_valid}, 0);
        chk("rst_rx_strobes", {port_rx_rd_valid, port_rx_wr_valid}, 0);
        chk("rst_outstanding", port_rd_outstanding, 0);
        chk("rst_err", err_bad_rsp, 0);
        chk("rst_stats", port_stats, 0);
        chk("rst_tx_payload", {afu_tx_rd_hdr, afu_tx_wr_hdr}, 0);
        chk("rst_data_payload", afu_tx_data | port_rx_data, 0);
        @(negedge clk);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        cycle();
    endtask

    // ------------------------------------------------------------- stimulus
    int order [6] = '{0, 1, 3, 0, 1, 3};

    initial begin
        b_rst_n      = 1'b0;
        b_rd_valid   = '0;
        b_wr_valid   = '0;
        b_rd_hdr     = '0;
        b_wr_hdr     = '0;
        b_wr_data    = '0;
        b_rx_rd_v    = 1'b0;
        b_rx_wr_v    = 1'b0;
        b_rx_rd_hdr  = '0;
        b_rx_wr_hdr  = '0;
        b_rx_rd_data = '0;
        rd_hdr       = '0;
        wr_hdr       = '0;
        wr_data      = '0;
        @(negedge clk);
        b_rst_n = 1'b1;
        reset_a();

        // Round robin with ports 0, 1 and 3 requesting continuously.
        for (int k = 0; k < 6; k++) begin
            rd_valid = 4'b1011;
            for (int i = 0; i < N; i++) rd_hdr[i] = rnd96()[73:0];
            #1;
            chk("rr_order", port_rd_ready, 4'b0001 << order[k]);
            cycle();
            chk("rr_mdata_pid", afu_tx_rd_hdr[15:14], order[k]);
        end
        idle();
        cycle();

        // Port 1 is granted while one of its reads returns: the count holds at 2.
        rd_valid  = 4'b0010;
        rd_hdr[1] = rnd96()[73:0];
        rx_rd_v   = 1'b1;
        rx_rd_hdr = 28'h0004123;
        cycle();
        chk("same_cycle_cnt", port_rd_outstanding[1], 7'd2);
        chk("same_cycle_mdata", port_rx_rd_hdr[15:0], 16'h0123);
        idle();

        // Almost-full rises in cycle 5 with every port requesting.
        for (int c = 1; c <= 7; c++) begin
            rd_valid = 4'b1111;
            rd_af    = (c >= 5);
            for (int i = 0; i < N; i++) rd_hdr[i] = rnd96()[73:0];
            #1;
            if (c >= 5) chk("af_no_ready", port_rd_ready, 0);
            if (c == 5) chk("af_last_issue", afu_tx_rd_valid, 1);
            cycle();
            if (c >= 5) chk("af_no_issue", afu_tx_rd_valid, 0);
        end
        idle();

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            int start, id;
            idle();
            rd_valid = 4'($urandom());
            wr_valid = 4'($urandom());
            rd_af    = ($urandom_range(0, 7) == 0);
            wr_af    = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < N; i++) begin
                rd_hdr[i]  = rnd96()[73:0];
                wr_hdr[i]  = rnd96()[79:0];
                wr_data[i] = rnd512();
            end
            id = -1;
            if ($urandom_range(0, 3) != 0) begin
                start = $urandom_range(0, N - 1);
                for (int k = 0; k < N; k++)
                    if (id < 0 && m_cnt[(start + k) % N] > 0) id = (start + k) % N;
            end else if ($urandom_range(0, 15) == 0) begin
                for (int p = 0; p < N; p++)
                    if (id < 0 && m_cnt[p] == 0 && !rd_valid[p]) id = p;
            end
            if (id >= 0) begin
                rx_rd_v    = 1'b1;
                rx_rd_hdr  = rsp_hdr(id);
                rx_rd_data = rnd512();
            end
            if ($urandom_range(0, 1) == 1) begin
                rx_wr_v   = 1'b1;
                rx_wr_hdr = rsp_hdr($urandom_range(0, N - 1));
            end
            cycle();
        end
        idle();
        cycle();

        // Read-grant statistics for ten reads from port 0.
        reset_a();
        for (int c = 0; c < 10; c++) begin
            rd_valid  = 4'b0001;
            rd_hdr[0] = rnd96()[73:0];
            cycle();
        end
        idle();
        cycle();
`ifdef CCIP_PORT_MUX_STATS_EN
        chk("stats_port0", port_stats[0], 32'd10);
`else
        chk("stats_port0", port_stats[0], 32'd0);
`endif
        chk("stats_others", {port_stats[3], port_stats[2], port_stats[1]}, 0);

        // Instance B: port 2 hits the 2-read cap, then the responses come back.
        b_rd_valid  = 3'b100;
        b_rd_hdr[2] = 74'h1234;
        #1;
        chk("b_ready_first", b_rd_ready, 3'b100);
        cycle();
        #1;
        chk("b_ready_second", b_rd_ready, 3'b100);
        cycle();
        chk("b_tx_valid", b_tx_rd_v, 1);
        chk("b_tx_mdata", b_tx_rd_hdr[15:0], 16'h9234);
        #1;
        chk("b_ready_capped", b_rd_ready, 3'b000);
        cycle();
        chk("b_cnt_capped", b_cnt[2], 2'd2);
        chk("b_no_tx", b_tx_rd_v, 0);
        b_rd_valid  = '0;
        b_rx_rd_v   = 1'b1;
        b_rx_rd_hdr = 28'h0008005;
        cycle();
        b_rx_rd_v = 1'b0;
        chk("b_rsp_strobe", b_prx_rd_v, 3'b100);
        chk("b_rsp_mdata", b_prx_rd_hdr[15:0], 16'h0005);
        chk("b_cnt_after_rsp", b_cnt[2], 2'd1);
        chk("b_err_clean", b_err, 0);
        cycle();
        chk("b_strobe_single", b_prx_rd_v, 3'b000);
        b_rx_rd_v   = 1'b1;
        b_rx_rd_hdr = 28'h000C000;
        cycle();
        b_rx_rd_v = 1'b0;
        chk("b_bad_id_no_strobe", b_prx_rd_v, 3'b000);
        chk("b_bad_id_err", b_err, 1);
        chk("b_bad_id_cnt", b_cnt[2], 2'd1);
        cycle();
        chk("b_err_sticky", b_err, 1);
        b_rst_n = 1'b0;
        #1;
        chk("b_err_reset", b_err, 0);
        chk("b_cnt_reset", b_cnt, 0);
        @(negedge clk);
        b_rst_n = 1'b1;
        cycle();
        chk("b_err_after_reset", b_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ccip_port_mux.md
# ccip_port_mux

Parametrised N-to-1 CCI-P request multiplexer and response demultiplexer that lets several SPL-style AFU engines share the single MPF-facing CCI-P port inside the AFU top. It round-robin arbitrates c0 read and c1 write requests, stamps the source port ID into the upper mdata bits, and bounds each port's outstanding reads. It routes read and write responses back to the originating port by that ID. It sits between the per-engine request logic and the `afu_tx_*` / `spl_rx_*` signals of the MPF-converted CCI-P port.

## Interface
- NUM_PORTS, 4, number of AFU ports (2..8); PID_W = $clog2(NUM_PORTS) is derived.
- MAX_OUTSTANDING, 64, per-port cap on in-flight reads (1..255); counter width CNT_W = $clog2(MAX_OUTSTANDING+1).
- Clock and reset: `clk` is the single clock. `spl_reset_n` is asynchronous, active-low.
- clk  in  1  AFU clock
- spl_reset_n  in  1  asynchronous active-low reset
- port_rd_valid / port_rd_ready  in / out  NUM_PORTS  per-port read request handshake
- port_rd_hdr  in  NUM_PORTS×$bits(t_ccip_c0_ReqMemHdr)  per-port read headers
- port_wr_valid / port_wr_ready  in / out  NUM_PORTS  per-port write request handshake
- port_wr_hdr  in  NUM_PORTS×$bits(t_ccip_c1_ReqMemHdr)  per-port write headers
- port_wr_data  in  NUM_PORTS×512  per-port write data
- port_rx_rd_valid / port_rx_wr_valid  out  NUM_PORTS  one-hot response strobes
- port_rx_rd_hdr, port_rx_data, port_rx_wr_hdr  out  response hdr/512/hdr  shared response payload
- port_rd_outstanding  out  NUM_PORTS×CNT_W  per-port in-flight read counts
- spl_tx_rd_almostfull, spl_tx_wr_almostfull  in  1  CCI-P back-pressure
- afu_tx_rd_valid, afu_tx_rd_hdr  out  1, c0 req hdr  merged read request
- afu_tx_wr_valid, afu_tx_wr_hdr, afu_tx_data  out  1, c1 req hdr, 512  merged write request
- spl_rx_rd_valid, spl_rx_rd_hdr, spl_rx_data  in  1, c0 rsp hdr, 512  read response
- spl_rx_wr_valid, spl_rx_wr_hdr  in  1, c1 rsp hdr  write response
- err_bad_rsp  out  1  sticky error flag
- port_stats  out  NUM_PORTS×32  read-request counters (see Configuration)

## Operation
- Two independent round-robin arbiters, one for reads (c0) and one for writes (c1). Each has a PID_W-bit priority pointer.
- Read eligibility: port i is eligible when `port_rd_valid[i]` is set, `!spl_tx_rd_almostfull` holds, and `port_rd_outstanding[i] < MAX_OUTSTANDING`.
- Write eligibility: port i is eligible when `port_wr_valid[i]` is set and `!spl_tx_wr_almostfull` holds.
- Grant: goes to the first eligible port at or after the pointer. The `ready` output is combinational and one-hot, or all zero.
- Pointer update: after a grant, the pointer moves to grant+1 mod NUM_PORTS. With no grant, it holds.
- Header stamping: the accepted header is registered with mdata[15:16-PID_W] overwritten by the port ID. Ports must confine their own tags to mdata[15-PID_W:0].
- Response routing: a response's port ID is taken from its mdata[15:16-PID_W]. Those bits are cleared in the returned hdr, and the matching strobe is pulsed.
- Outstanding counter: increments on a read grant and decrements on a read response to that port. When both happen in the same cycle, the counter is unchanged.
- Error cases: a response whose ID is ≥ NUM_PORTS is dropped and sets `err_bad_rsp`. A read response to a port whose counter is 0 is delivered, the counter is not decremented, and `err_bad_rsp` is set.
- `err_bad_rsp` stays set until reset.
- Write responses are passed through unchanged apart from the ID handling above. No write counters are kept.

## Timing
- Request latency: a grant in cycle N drives `afu_tx_*_valid` high in cycle N+1 for exactly one cycle per grant.
- Throughput: back-to-back grants are allowed, giving 1 request per cycle per channel.
- Response latency: `spl_rx_*_valid` in cycle M drives `port_rx_*` in cycle M+1.
- `port_rd_outstanding` updates in the cycle after the grant or response.
- Almost-full: the almost-full inputs are sampled combinationally, so no grant occurs in any cycle where almost-full is high. At most one already-registered request issues after it rises.
- Reset state: while `spl_reset_n` is low, and immediately after it deasserts, all valids, readies, strobes, counters, pointers, `err_bad_rsp` and `port_stats` are 0. Payload outputs are 0.
- Reset mid-operation: in-flight requests are discarded and responses that arrive later are handled by the normal ID rules.

## Configuration
- `CCIP_PORT_MUX_STATS_EN` defined: `port_stats[i]` is a 32-bit counter that increments on each read grant to port i. It wraps at 2^32 and is cleared by reset.
- Macro undefined: `port_stats` is tied to 0 and no counter logic is built.

## Test plan
- Ports 0, 1 and 3 hold `rd_valid` continuously with almost-full low. Required: grants in the order 0,1,3,0,1,3. `afu_tx_rd_hdr` mdata[15:14] equals 0,1,3 in turn, with one request per cycle.
- Almost-full is raised in cycle 5 while all ports are valid. Required: no `rd_ready` in cycles 5 onward, and only the request granted in cycle 4 issues, in cycle 5.
- With MAX_OUTSTANDING=2, port 2 issues 2 reads with no responses. Required: `rd_ready[2]` stays 0 and the outstanding count is 2. After one response with mdata 0x8005, `port_rx_rd_valid[2]` pulses with mdata 0x0005 and the count returns to 1.
- A read grant to port 1 and a response for port 1 occur in the same cycle. Required: the count is unchanged.
- With NUM_PORTS=3, a response arrives with ID 3. Required: no strobe and `err_bad_rsp` becomes 1. A later reset clears it.
- With the stats macro defined, port 0 issues 10 reads. Required: `port_stats[0]` = 10 and all other entries 0. With the macro undefined, all entries are 0.
